piso_serializer: RTL and testbench
==================================

// Module: piso_serializer
// PURPOSE
//   Parallel-in/serial-out shifter driving the D input of the d_flipflop retiming stage.
//   Captures a WIDTH-bit word on Load and presents it MSB-first on SerialOut, one bit per enabled Clock.
//   Busy/Done form the upstream handshake.
// PARAMETERS
//   WIDTH  4  data word width in bits; legal range >= 2
// PORTS
//   Clock       in   1      single clock, all state updates on posedge
//   Clear       in   1      reset, synchronous, active-high; priority over every other input
//   Load        in   1      request to capture ParallelIn; accepted only when Busy=0
//   ParallelIn  in   WIDTH  word to serialise, sampled on the accepting edge
//   Enable      in   1      shift enable in SHIFT state; 0 stalls, holding SerialOut and count
//   SerialOut   out  1      registered serial bit, MSB first; 0 when idle
//   Busy        out  1      1 while a frame is in progress (SHIFT state)
//   Done        out  1      one-cycle pulse after the last bit of a frame
// BEHAVIOUR
//   - Clear=1 at posedge: state=IDLE, shreg=0, count=0, SerialOut=0, Busy=0, Done=0. Applies mid-frame; the frame is dropped.
//   - All outputs are registered; no combinational input-to-output path.
//   - FSM states:
//     - IDLE: SerialOut=0, Busy=0, Done=0.
//       - Load=1: SerialOut<=ParallelIn[WIDTH-1], shreg<=ParallelIn<<1, count<=1, Busy<=1, go SHIFT.
//       - Load=0: stay in IDLE.
//     - SHIFT, Enable=1, count<NBITS: SerialOut<=shreg[WIDTH-1], shreg<=shreg<<1 (zero fill), count<=count+1.
//     - SHIFT, Enable=1, count==NBITS: SerialOut<=0, Busy<=0, Done<=1, go DONE.
//     - SHIFT, Enable=0: hold all state; Done stays 0.
//     - DONE: Done=1 for exactly this cycle, Busy=0.
//       - Load=1: accepted exactly as from IDLE (back-to-back frames, no gap cycle).
//       - Load=0: go IDLE; Done<=0.
//   - Load while Busy=1 is ignored, with no effect on shreg or count.
//   - Latency: first bit on SerialOut in the cycle after the accepting edge.
//     Bit k (k=0 is the MSB) is valid for the duration of the k-th enabled SHIFT cycle.
//   - NBITS = WIDTH (no parity) or WIDTH+1 (parity). count width = $clog2(NBITS+1); count never wraps.
//   - Enable is ignored in IDLE and DONE. Enable=0 on the accepting edge does not block the load.
// CONFIGURATION
//   - Macro PISO_SERIALIZER_PARITY_EN.
//   - Defined:
//     - Parity register <= ^ParallelIn on the accepting edge.
//     - After the WIDTH data bits, one extra enabled cycle presents the even-parity bit on SerialOut, then DONE.
//     - NBITS=WIDTH+1.
//   - Undefined: no parity register; frame is WIDTH bits; NBITS=WIDTH.
// STRUCTURE
//   - Shared package piso_pkg:
//     - state enum {IDLE, SHIFT, DONE} (2-bit encoding)
//     - localparam PISO_MIN_WIDTH=2
//     - function cnt_width(n) returning $clog2(n+1)
//   - No sub-modules: FSM, shift register and bit counter are in one module.
//   - The parameter check (WIDTH < PISO_MIN_WIDTH) raises an elaboration-time error.
// TESTING (WIDTH=4)
//   1. Clear=1 for 2 cycles with Load=1, ParallelIn=4'hF -> SerialOut=0, Busy=0, Done=0 throughout.
//   2. Load 4'b1011, Enable=1 -> SerialOut 1,0,1,1 on cycles 1-4, Busy=1 on cycles 1-4, Done=1 on cycle 5 only.
//   3. Load 4'b1100; Enable=0 for 3 cycles after bit 1 -> SerialOut holds 1 for the stall; full sequence 1,1,0,0; Done one cycle late per stall cycle.
//   4. Load 4'b1001, then Load 4'b0110 while Busy=1 -> output stays 1,0,0,1; second word not sent.
//   5. Clear asserted during bit 2 -> next cycle SerialOut=0, Busy=0, Done=0, no Done pulse; next Load starts a clean frame.
//   6. PISO_SERIALIZER_PARITY_EN defined, Load 4'b1011 -> 1,0,1,1 then 1 (parity), Done on cycle 6; back-to-back Load during DONE starts the next frame the following cycle.

Source files
------------

// File: rtl/piso_serializer_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
// Holds the FSM state encoding, the minimum legal width and the counter width helper.
package piso_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int PISO_MIN_WIDTH = 2;

   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter: captures a word on Load and sends it MSB-first, one bit per enabled cycle.
// Optional even-parity trailer bit when PISO_SERIALIZER_PARITY_EN is defined.
module piso_serializer
   import piso_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             Clock,
   input  logic             Clear,
   input  logic             Load,
   input  logic [WIDTH-1:0] ParallelIn,
   input  logic             Enable,
   output logic             SerialOut,
   output logic             Busy,
   output logic             Done
);

`ifdef PISO_SERIALIZER_PARITY_EN
   localparam int NBITS = WIDTH + 1;
`else
   localparam int NBITS = WIDTH;
`endif
   localparam int CW = cnt_width(NBITS);
   localparam logic [CW-1:0] LAST_COUNT = CW'(NBITS);

   generate
      if (WIDTH < PISO_MIN_WIDTH) begin : gWidthCheck
         $error("piso_serializer: WIDTH must be at least PISO_MIN_WIDTH");
      end
   endgenerate

   state_t           state, stateNext;
   logic [WIDTH-1:0] shreg, shregNext;
   logic [CW-1:0]    count, countNext;
   logic             serialNext, busyNext, doneNext;

`ifdef PISO_SERIALIZER_PARITY_EN
   localparam logic [CW-1:0] DATA_END = CW'(WIDTH);
   logic             parity, parityNext;
`endif

   // Next-state and next-output logic; every register update is decided here.
   always_comb begin
      stateNext  = state;
      shregNext  = shreg;
      countNext  = count;
      serialNext = SerialOut;
      busyNext   = Busy;
      doneNext   = 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
      parityNext = parity;
`endif
      case (state)
         IDLE, DONE: begin
            stateNext  = IDLE;
            serialNext = 1'b0;
            busyNext   = 1'b0;
            if (Load) begin
               stateNext  = SHIFT;
               serialNext = ParallelIn[WIDTH-1];
               shregNext  = ParallelIn << 1;
               countNext  = CW'(1);
               busyNext   = 1'b1;
`ifdef PISO_SERIALIZER_PARITY_EN
               parityNext = ^ParallelIn;
`endif
            end
         end
         SHIFT: begin
            if (Enable) begin
               if (count < LAST_COUNT) begin
`ifdef PISO_SERIALIZER_PARITY_EN
                  serialNext = (count == DATA_END) ? parity : shreg[WIDTH-1];
`else
                  serialNext = shreg[WIDTH-1];
`endif
                  shregNext  = shreg << 1;
                  countNext  = count + CW'(1);
               end else begin
                  stateNext  = DONE;
                  serialNext = 1'b0;
                  busyNext   = 1'b0;
                  doneNext   = 1'b1;
               end
            end
         end
         default: begin
            stateNext  = IDLE;
            serialNext = 1'b0;
            busyNext   = 1'b0;
         end
      endcase
   end

   // State and output registers; Clear drops any frame in flight.
   always_ff @(posedge Clock) begin
      if (Clear) begin
         state     <= IDLE;
         shreg     <= '0;
         count     <= '0;
         SerialOut <= 1'b0;
         Busy      <= 1'b0;
         Done      <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
         parity    <= 1'b0;
`endif
      end else begin
         state     <= stateNext;
         shreg     <= shregNext;
         count     <= countNext;
         SerialOut <= serialNext;
         Busy      <= busyNext;
         Done      <= doneNext;
`ifdef PISO_SERIALIZER_PARITY_EN
         parity    <= parityNext;
`endif
      end
   end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer (WIDTH=4); directed vectors, parity steps added when PISO_SERIALIZER_PARITY_EN is defined.
module tb_piso_serializer;

   logic       Clock = 1'b0;
   logic       Clear = 1'b1;
   logic       Load = 1'b0;
   logic [3:0] ParallelIn = 4'h0;
   logic       Enable = 1'b0;
   logic       SerialOut, Busy, Done;

   int checks = 0;
   int errors = 0;

   logic [2:0] expQ[$];
   string      nameQ[$];

   piso_serializer #(.WIDTH(4)) dut (
      .Clock      (Clock),
      .Clear      (Clear),
      .Load       (Load),
      .ParallelIn (ParallelIn),
      .Enable     (Enable),
      .SerialOut  (SerialOut),
      .Busy       (Busy),
      .Done       (Done)
   );

   always #5 Clock = ~Clock;

   // Drive one cycle of inputs and queue the outputs expected after the next edge.
   task automatic applyStimulus(input string name, input logic clr, input logic ld,
                                input logic [3:0] pi, input logic en,
                                input logic eSo, input logic eBusy, input logic eDone);
      @(negedge Clock);
      Clear      = clr;
      Load       = ld;
      ParallelIn = pi;
      Enable     = en;
      expQ.push_back({eSo, eBusy, eDone});
      nameQ.push_back(name);
   endtask

   task automatic parityStep(input string name, input logic eBit);
`ifdef PISO_SERIALIZER_PARITY_EN
      applyStimulus(name, 1'b0, 1'b0, 4'h0, 1'b1, eBit, 1'b1, 1'b0);
`endif
   endtask

   task automatic checkOutput(input string name, input logic [2:0] expected);
      checks++;
      if ({SerialOut, Busy, Done} !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got SerialOut/Busy/Done=%b%b%b, expected %b",
                  name, SerialOut, Busy, Done, expected);
      end
   endtask

   // Monitor: compares the DUT against the head of the scoreboard just after each edge.
   initial begin
      forever begin
         @(posedge Clock);
         #1;
         if (expQ.size() > 0) begin
            checkOutput(nameQ.pop_front(), expQ.pop_front());
         end
      end
   end

   initial begin
      // Clear dominates Load
      applyStimulus("t1 clear0", 1, 1, 4'hF, 1, 0, 0, 0);
      applyStimulus("t1 clear1", 1, 1, 4'hF, 1, 0, 0, 0);
      applyStimulus("t1 idle",   0, 0, 4'h0, 1, 0, 0, 0);

      // Basic frame 1011
      applyStimulus("t2 bit0", 0, 1, 4'b1011, 1, 1, 1, 0);
      applyStimulus("t2 bit1", 0, 0, 4'h0,    1, 0, 1, 0);
      applyStimulus("t2 bit2", 0, 0, 4'h0,    1, 1, 1, 0);
      applyStimulus("t2 bit3", 0, 0, 4'h0,    1, 1, 1, 0);
      parityStep("t2 parity", 1);
      applyStimulus("t2 done", 0, 0, 4'h0,    1, 0, 0, 1);
      applyStimulus("t2 idle", 0, 0, 4'h0,    1, 0, 0, 0);
      applyStimulus("t2 idle en", 0, 0, 4'h0, 1, 0, 0, 0);

      // Frame 1100, loaded with Enable=0, then stalled three cycles after bit 0
      applyStimulus("t3 bit0",   0, 1, 4'b1100, 0, 1, 1, 0);
      applyStimulus("t3 stall0", 0, 0, 4'h0,    0, 1, 1, 0);
      applyStimulus("t3 stall1", 0, 0, 4'h0,    0, 1, 1, 0);
      applyStimulus("t3 stall2", 0, 0, 4'h0,    0, 1, 1, 0);
      applyStimulus("t3 bit1",   0, 0, 4'h0,    1, 1, 1, 0);
      applyStimulus("t3 bit2",   0, 0, 4'h0,    1, 0, 1, 0);
      applyStimulus("t3 bit3",   0, 0, 4'h0,    1, 0, 1, 0);
      parityStep("t3 parity", 0);
      applyStimulus("t3 done",   0, 0, 4'h0,    1, 0, 0, 1);
      applyStimulus("t3 idle",   0, 0, 4'h0,    0, 0, 0, 0);

      // Frame 1001 with a second Load of 0110 while busy
      applyStimulus("t4 bit0", 0, 1, 4'b1001, 1, 1, 1, 0);
      applyStimulus("t4 bit1", 0, 1, 4'b0110, 1, 0, 1, 0);
      applyStimulus("t4 bit2", 0, 1, 4'b0110, 1, 0, 1, 0);
      applyStimulus("t4 bit3", 0, 1, 4'b0110, 1, 1, 1, 0);
      parityStep("t4 parity", 0);
      applyStimulus("t4 done", 0, 0, 4'h0,    1, 0, 0, 1);
      applyStimulus("t4 idle", 0, 0, 4'h0,    1, 0, 0, 0);

      // Clear during bit 2 drops the frame; a fresh frame follows
      applyStimulus("t5 bit0",  0, 1, 4'b1011, 1, 1, 1, 0);
      applyStimulus("t5 bit1",  0, 0, 4'h0,    1, 0, 1, 0);
      applyStimulus("t5 bit2",  0, 0, 4'h0,    1, 1, 1, 0);
      applyStimulus("t5 clear", 1, 1, 4'hF,    1, 0, 0, 0);
      applyStimulus("t5 nodone", 0, 0, 4'h0,   1, 0, 0, 0);
      applyStimulus("t5 new bit0", 0, 1, 4'b0110, 1, 0, 1, 0);
      applyStimulus("t5 new bit1", 0, 0, 4'h0,    1, 1, 1, 0);
      applyStimulus("t5 new bit2", 0, 0, 4'h0,    1, 1, 1, 0);
      applyStimulus("t5 new bit3", 0, 0, 4'h0,    1, 0, 1, 0);
      parityStep("t5 parity", 0);
      applyStimulus("t5 done",  0, 0, 4'h0,    1, 0, 0, 1);

      // Back-to-back Load accepted in the DONE cycle
      applyStimulus("t6 b2b bit0", 0, 1, 4'b0101, 1, 0, 1, 0);
      applyStimulus("t6 bit1",     0, 0, 4'h0,    1, 1, 1, 0);
      applyStimulus("t6 bit2",     0, 0, 4'h0,    1, 0, 1, 0);
      applyStimulus("t6 bit3",     0, 0, 4'h0,    1, 1, 1, 0);
      parityStep("t6 parity", 0);
      applyStimulus("t6 done",     0, 0, 4'h0,    1, 0, 0, 1);
      applyStimulus("t6 idle",     0, 0, 4'h0,    1, 0, 0, 0);

      for (int i = 0; i < 10 && expQ.size() > 0; i++) begin
         @(posedge Clock);
         #2;
      end
      if (expQ.size() > 0) begin
         errors++;
         $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
